// File: rtl/vga_frame_scheduler.sv
// 640x480@60 raster timing, frame-buffer read addressing and double-buffer swap control.
// Read latency is absorbed by delaying blank/sync so RGB, HSYNC and VSYNC leave aligned.
module vga_frame_scheduler #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int RD_LAT   = 1
) (
   input  logic        sysclk,
   input  logic        sysrst,
   input  logic [11:0] pixel_data,
   output logic [18:0] read_address,
   output logic        buf_sel,
   input  logic        swap_req,
   output logic        swap_ack,
   output logic        frame_start,
   output logic [3:0]  vga_out_r,
   output logic [3:0]  vga_out_g,
   output logic [3:0]  vga_out_b,
   output logic        vga_out_hs,
   output logic        vga_out_vs
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DEPTH   = RD_LAT + 2;

   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0]       h_cnt;
   logic [9:0]       v_cnt;
   logic             active;
   logic             hs_slot;
   logic             vs_slot;
   logic             frame_origin;
   logic             decision_slot;
   logic [RD_LAT:0]  act_pipe;
   logic [DEPTH-1:0] hs_pipe;
   logic [DEPTH-1:0] vs_pipe;
   logic [11:0]      rgb;

   assign active        = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs_slot       = !((h_cnt >= HS_START) && (h_cnt < HS_END));
   assign vs_slot       = !((v_cnt >= VS_START) && (v_cnt < VS_END));
   assign frame_origin  = (h_cnt == 10'd0) && (v_cnt == 10'd0);
   // First blank line: every read of the previous frame has already returned.
   assign decision_slot = (h_cnt == 10'd0) && (v_cnt == V_ACT);

   always_ff @(posedge sysclk) begin
      if (!sysrst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
         h_cnt <= h_cnt + 10'd1;
      end
   end

   // The address register doubles as the pixel counter: it holds through blanking.
   always_ff @(posedge sysclk) begin
      if (!sysrst) begin
         read_address <= '0;
         frame_start  <= 1'b0;
      end else begin
         frame_start <= frame_origin;
         if (frame_origin)
            read_address <= '0;
         else if (active)
            read_address <= read_address + 19'd1;
      end
   end

   always_ff @(posedge sysclk) begin
      if (!sysrst) begin
         buf_sel  <= 1'b0;
         swap_ack <= 1'b0;
      end else begin
         swap_ack <= decision_slot && swap_req;
         if (decision_slot && swap_req)
            buf_sel <= ~buf_sel;
      end
   end

   // act_pipe[RD_LAT] lines up with the pixel_data word for the same slot.
   always_ff @(posedge sysclk) begin
      if (!sysrst) begin
         act_pipe <= '0;
         hs_pipe  <= '1;
         vs_pipe  <= '1;
         rgb      <= '0;
      end else begin
         act_pipe <= {act_pipe[RD_LAT-1:0], active};
         hs_pipe  <= {hs_pipe[DEPTH-2:0], hs_slot};
         vs_pipe  <= {vs_pipe[DEPTH-2:0], vs_slot};
         rgb      <= act_pipe[RD_LAT] ? pixel_data : 12'd0;
      end
   end

   assign vga_out_r  = rgb[11:8];
   assign vga_out_g  = rgb[7:4];
   assign vga_out_b  = rgb[3:0];
   assign vga_out_hs = hs_pipe[DEPTH-1];
   assign vga_out_vs = vs_pipe[DEPTH-1];

endmodule
